// File: rtl/rom_arbiter_if.sv
// Request/response bundle between the three bus masters and rom_arbiter.
// Index 0 = debug loader, 1 = core data, 2 = core fetch.
interface rom_arbiter_if #(
   parameter int AddrWidth = 32,
   parameter int DataWidth = 32
);
   logic [2:0]           req_i;
   logic [2:0]           we_i;
   logic [AddrWidth-1:0] addr_i  [3];
   logic [DataWidth-1:0] wdata_i [3];
   logic [2:0]           gnt_o;
   logic [2:0]           rvalid_o;
   logic [DataWidth-1:0] rdata_o;
   logic                 err_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface

// File: rtl/rom_arbiter.sv
// Three-port arbiter for the shared instruction ROM: fixed priority for the
// debug loader, round-robin between core data/fetch, checked access, debug lock.
module rom_arbiter #(
   parameter int AddrWidth    = 32,
   parameter int DataWidth    = 32,
   parameter int NumWords     = 4096,
   parameter bit WriteProtect = 1'b1,
   parameter int LockTimeout  = 65535
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   rom_arbiter_if.slave         bus,
   input  logic                 dbg_lock_i,
   output logic                 lock_active_o,
   output logic                 lock_timeout_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   localparam logic [0:0] StUnlocked = 1'b0;
   localparam logic [0:0] StLocked   = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 timeout_q, timeout_d;
   logic [1:0]           rr_q, rr_d;
   logic [2:0]           rvalid_q;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic [2:0]           eligible;
   logic [2:0]           gnt;
   logic [1:0]           sel;
   logic                 any_gnt;
   logic [AddrWidth-1:0] sel_addr;
   logic                 sel_we;
   logic                 req_err;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      eligible = bus.req_i;
      if (state_q == StLocked) eligible = eligible & 3'b001;
      if (rst_i)               eligible = 3'b000;

      gnt = 3'b000;
      if (eligible[0])                     gnt = 3'b001;
      else if (eligible[1] && eligible[2]) gnt = (rr_q == 2'd2) ? 3'b100 : 3'b010;
      else if (eligible[1])                gnt = 3'b010;
      else if (eligible[2])                gnt = 3'b100;

      unique case (gnt)
         3'b001:  sel = 2'd0;
         3'b100:  sel = 2'd2;
         default: sel = 2'd1;
      endcase
      any_gnt  = |gnt;
      sel_addr = bus.addr_i[sel];
      sel_we   = bus.we_i[sel];

      // Out-of-range and protected writes still take the slot; only the ROM
      // strobe and the response change.
      req_err = (sel_addr[1:0] != 2'b00)
             || ({2'b00, sel_addr[AddrWidth-1:2]} >= AddrWidth'(NumWords))
             || (WriteProtect && sel_we && (sel != 2'd0));

      mem_we_o    = any_gnt && sel_we && !req_err;
      mem_addr_o  = any_gnt ? sel_addr : '0;
      mem_wdata_o = any_gnt ? bus.wdata_i[sel] : '0;

      rdata_d = (any_gnt && !sel_we && !req_err) ? mem_rdata_i : '0;
      err_d   = any_gnt && req_err;

      rr_d = rr_q;
      if (gnt[1]) rr_d = 2'd2;
      if (gnt[2]) rr_d = 2'd1;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (!dbg_lock_i) timeout_d = 1'b0;

      unique case (state_q)
         StUnlocked: begin
            // A sticky timeout keeps the loader out until it drops its lock request.
            if (dbg_lock_i && !timeout_q) begin
               state_d = StLocked;
               cnt_d   = '0;
            end
         end
         StLocked: begin
            if (!dbg_lock_i) begin
               state_d = StUnlocked;
            end else if (cnt_q == 16'(LockTimeout - 1)) begin
               state_d   = StUnlocked;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StUnlocked;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StUnlocked;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         rr_q      <= 2'd1;
         rvalid_q  <= 3'b000;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         rr_q      <= rr_d;
         rvalid_q  <= gnt;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign bus.gnt_o      = gnt;
   assign bus.rvalid_o   = rvalid_q;
   assign bus.rdata_o    = rdata_q;
   assign bus.err_o      = err_q;
   assign lock_active_o  = (state_q == StLocked);
   assign lock_timeout_o = timeout_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed and randomized bench for rom_arbiter with a behavioural reference
// model (pending-request table, round-robin favourite, expected ROM contents).
module tb_rom_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NW = 4096;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          dbg_lock = 1'b0;
   logic          lock_active, lock_timeout;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic [DW-1:0] rom     [NW];
   logic [DW-1:0] ref_mem [NW];

   int checks = 0;
   int errors = 0;

   rom_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

   rom_arbiter #(
      .AddrWidth(AW), .DataWidth(DW), .NumWords(NW),
      .WriteProtect(1'b1), .LockTimeout(8)
   ) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .dbg_lock_i(dbg_lock),
      .lock_active_o(lock_active), .lock_timeout_o(lock_timeout),
      .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = rom[mem_addr[13:2]];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; the ROM model commits the write strobe seen before the edge.
   task automatic tick();
      logic          we_s;
      logic [AW-1:0] a_s;
      logic [DW-1:0] d_s;
      we_s = mem_we;
      a_s  = mem_addr;
      d_s  = mem_wdata;
      @(posedge clk);
      if (we_s) rom[a_s[13:2]] = d_s;
      #1;
   endtask

   task automatic idle();
      bus.req_i = 3'b000;
      bus.we_i  = 3'b000;
      for (int p = 0; p < 3; p++) begin
         bus.addr_i[p]  = '0;
         bus.wdata_i[p] = '0;
      end
   endtask

   task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.req_i[p]   = 1'b1;
      bus.we_i[p]    = we;
      bus.addr_i[p]  = a;
      bus.wdata_i[p] = d;
   endtask

   // Reference model state for the randomized phase
   logic          pend  [3];
   logic          pwe   [3];
   logic [AW-1:0] paddr [3];
   logic [DW-1:0] pwd   [3];
   int            rr_m;

   initial begin
      int          g, lock_cycles;
      logic [2:0]  exp_gnt, grant_seq [4];
      logic        e_err, e_we;
      logic [DW-1:0] e_rdata;
      logic [11:0] idx;
      logic [AW-1:0] a;

      for (int i = 0; i < NW; i++) begin
         rom[i]     = $urandom;
         ref_mem[i] = rom[i];
      end
      rom[2] = 32'hDEADBEEF;
      ref_mem[2] = 32'hDEADBEEF;

      // Reset with all ports requesting: no grant, no strobe, quiet outputs
      idle();
      bus.req_i = 3'b111;
      tick();
      check("rst_gnt", bus.gnt_o, 3'b000);
      check("rst_mem_we", mem_we, 1'b0);
      tick();
      check("rst_rvalid", bus.rvalid_o, 3'b000);
      check("rst_rdata", bus.rdata_o, 32'h0);
      check("rst_err", bus.err_o, 1'b0);
      check("rst_lock", lock_active, 1'b0);
      check("rst_timeout", lock_timeout, 1'b0);
      rst = 1'b0;
      idle();
      tick();

      // Port 1 read of word 2
      set_req(1, 1'b0, 32'h8, 32'h0);
      #1;
      check("rd_gnt", bus.gnt_o, 3'b010);
      check("rd_mem_addr", mem_addr, 32'h8);
      tick();
      idle();
      check("rd_rvalid", bus.rvalid_o, 3'b010);
      check("rd_rdata", bus.rdata_o, 32'hDEADBEEF);
      check("rd_err", bus.err_o, 1'b0);

      // Reset while a response is pending drops it
      set_req(1, 1'b0, 32'h8, 32'h0);
      #1;
      tick();
      idle();
      rst = 1'b1;
      check("rstpend_rvalid_before", bus.rvalid_o, 3'b010);
      tick();
      check("rstpend_rvalid_after", bus.rvalid_o, 3'b000);
      rst = 1'b0;

      // Round-robin between ports 1 and 2, then port 0 interjects
      grant_seq[0] = 3'b010; grant_seq[1] = 3'b100; grant_seq[2] = 3'b010; grant_seq[3] = 3'b100;
      for (int c = 0; c < 4; c++) begin
         set_req(1, 1'b0, 32'h0, 32'h0);
         set_req(2, 1'b0, 32'h4, 32'h0);
         #1;
         check($sformatf("rr_gnt%0d", c), bus.gnt_o, grant_seq[c]);
         tick();
      end
      grant_seq[2] = 3'b001; grant_seq[3] = 3'b010;
      for (int c = 0; c < 4; c++) begin
         idle();
         set_req(1, 1'b0, 32'h0, 32'h0);
         set_req(2, 1'b0, 32'h4, 32'h0);
         if (c == 2) set_req(0, 1'b0, 32'hC, 32'h0);
         #1;
         check($sformatf("p0_gnt%0d", c), bus.gnt_o, grant_seq[c]);
         tick();
      end
      idle();

      // Write protection, privileged write, back-to-back read
      set_req(2, 1'b1, 32'h10, 32'hCAFEF00D);
      #1;
      check("wp_gnt", bus.gnt_o, 3'b100);
      check("wp_mem_we", mem_we, 1'b0);
      tick();
      idle();
      check("wp_err", bus.err_o, 1'b1);
      check("wp_rdata", bus.rdata_o, 32'h0);
      set_req(0, 1'b1, 32'h10, 32'h12345678);
      #1;
      check("p0w_mem_we", mem_we, 1'b1);
      check("p0w_mem_wdata", mem_wdata, 32'h12345678);
      ref_mem[4] = 32'h12345678;
      tick();
      idle();
      check("p0w_rvalid", bus.rvalid_o, 3'b001);
      check("p0w_err", bus.err_o, 1'b0);
      set_req(2, 1'b0, 32'h10, 32'h0);
      #1;
      tick();
      idle();
      check("b2b_rdata", bus.rdata_o, 32'h12345678);
      check("b2b_rvalid", bus.rvalid_o, 3'b100);

      // Misaligned and out-of-range requests
      set_req(1, 1'b0, 32'h6, 32'h0);
      #1;
      check("mis_gnt", bus.gnt_o, 3'b010);
      tick();
      idle();
      check("mis_err", bus.err_o, 1'b1);
      check("mis_rdata", bus.rdata_o, 32'h0);
      set_req(0, 1'b1, NW * 4, 32'h55AA55AA);
      #1;
      check("oor_gnt", bus.gnt_o, 3'b001);
      check("oor_mem_we", mem_we, 1'b0);
      tick();
      idle();
      check("oor_err", bus.err_o, 1'b1);
      check("oor_rdata", bus.rdata_o, 32'h0);
      check("oor_rom0", rom[0], ref_mem[0]);

      // Debug lock: same-cycle request still served, then exclusion
      dbg_lock = 1'b1;
      set_req(1, 1'b0, 32'h0, 32'h0);
      #1;
      check("lk_first_gnt", bus.gnt_o, 3'b010);
      tick();
      check("lk_active", lock_active, 1'b1);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("lk_block%0d", c), bus.gnt_o, 3'b000);
         tick();
      end
      set_req(0, 1'b0, 32'h0, 32'h0);
      #1;
      check("lk_p0_gnt", bus.gnt_o, 3'b001);
      tick();
      bus.req_i[0] = 1'b0;
      dbg_lock = 1'b0;
      #1;
      check("lk_drop_gnt", bus.gnt_o, 3'b000);
      tick();
      check("lk_released", lock_active, 1'b0);
      check("lk_release_gnt", bus.gnt_o, 3'b010);
      tick();
      idle();

      // Lock timeout after 8 locked cycles
      dbg_lock = 1'b1;
      tick();
      set_req(1, 1'b0, 32'h0, 32'h0);
      #1;
      lock_cycles = 0;
      while (lock_active && lock_cycles < 20) begin
         lock_cycles++;
         check("to_block_gnt", bus.gnt_o, 3'b000);
         tick();
      end
      check("to_lock_cycles", lock_cycles, 8);
      check("to_flag", lock_timeout, 1'b1);
      check("to_p1_served", bus.gnt_o, 3'b010);
      tick();
      idle();
      tick();
      check("to_stay_unlocked", lock_active, 1'b0);
      check("to_sticky", lock_timeout, 1'b1);
      dbg_lock = 1'b0;
      tick();
      check("to_cleared", lock_timeout, 1'b0);

      // Randomized traffic against the reference model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rr_m = 1;
      for (int p = 0; p < 3; p++) pend[p] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int p = 0; p < 3; p++) begin
            if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
               pend[p]  = 1'b1;
               pwe[p]   = $urandom_range(0, 2) == 0;
               pwd[p]   = $urandom;
               a        = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
               case ($urandom_range(0, 9))
                  0: a[1:0] = 2'($urandom_range(1, 3));
                  1: a = NW * 4 + a;
                  default: ;
               endcase
               paddr[p] = a;
            end
         end
         idle();
         for (int p = 0; p < 3; p++) if (pend[p]) set_req(p, pwe[p], paddr[p], pwd[p]);

         if (pend[0])                  g = 0;
         else if (pend[1] && pend[2])  g = rr_m;
         else if (pend[1])             g = 1;
         else if (pend[2])             g = 2;
         else                          g = -1;
         exp_gnt = (g < 0) ? 3'b000 : 3'(1 << g);

         e_err = 1'b0;
         e_we  = 1'b0;
         e_rdata = '0;
         if (g >= 0) begin
            idx   = paddr[g][13:2];
            e_err = (paddr[g] % 4 != 0) || (paddr[g] / 4 >= NW) || (pwe[g] && g != 0);
            e_we  = pwe[g] && !e_err;
            if (!e_err && !pwe[g]) e_rdata = ref_mem[idx];
         end
         #1;
         check("rnd_gnt", bus.gnt_o, exp_gnt);
         check("rnd_mem_we", mem_we, e_we);
         if (e_we) begin
            ref_mem[idx] = pwd[g];
            pend[g] = 1'b0;
         end
         tick();
         check("rnd_rvalid", bus.rvalid_o, exp_gnt);
         check("rnd_err", bus.err_o, e_err);
         check("rnd_rdata", bus.rdata_o, e_rdata);
         if (g >= 0) begin
            pend[g] = 1'b0;
            if (g == 1) rr_m = 2;
            if (g == 2) rr_m = 1;
         end
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Three-port arbiter and access controller for the shared instruction ROM. Serializes requests from the debug loader, the core data port and the core fetch port onto the ROM's single address/write port. Enforces alignment, range and write-protection checks, and returns registered read data. It sits between the bus masters and the ROM word array, which has a combinational read and a write on the clock edge.

## Interface
Parameters:
- AddrWidth, 32: request address width (byte address).
- DataWidth, 32: data word width.
- NumWords, 4096: ROM depth in words; word index = addr[AddrWidth-1:2].
- WriteProtect, 1: when 1, writes from ports 1 and 2 are rejected with error; port 0 may always write.
- LockTimeout, 65535: maximum cycles a debug lock may be held, 16-bit counter.

Ports (port index 0 = debug loader, 1 = core data, 2 = core fetch):
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  3  per-port request; held high until granted.
- we_i  in  3  per-port write enable, qualified by req_i.
- addr_i  in  3 x AddrWidth  per-port byte address.
- wdata_i  in  3 x DataWidth  per-port write data.
- gnt_o  out  3  one-hot grant, combinational, same cycle as the accepted request.
- rvalid_o  out  3  one-hot response valid, one cycle after grant; asserted for writes too.
- rdata_o  out  DataWidth  read data for the port flagged by rvalid_o; 0 on write or error.
- err_o  out  1  error flag accompanying rvalid_o.
- dbg_lock_i  in  1  debug loader requests exclusive access.
- lock_active_o  out  1  registered; exclusive mode in effect.
- lock_timeout_o  out  1  registered, sticky; lock was forcibly released.
- mem_we_o  out  1  ROM write strobe.
- mem_addr_o  out  AddrWidth  ROM byte address.
- mem_wdata_o  out  DataWidth  ROM write data.
- mem_rdata_i  in  DataWidth  ROM combinational read data.

## Operation
- At most one grant per cycle. Eligible ports are the ports with req_i high. In LOCKED state only port 0 is eligible.
- Priority: port 0 always wins. Ports 1 and 2 share round-robin: pointer rr = port to favour next; after granting port 1 or 2, rr moves to the other port. A port-0 grant leaves rr unchanged. rr resets to 1.
- Error request: addr[1:0] != 0, or word index >= NumWords, or (WriteProtect and we and port != 0). An error request is still granted and consumes the slot. It drives mem_we_o = 0 and responds with err_o = 1 and rdata_o = 0.
- Valid write: mem_we_o = 1, mem_addr_o/mem_wdata_o from the granted port. Response has err_o = 0, rdata_o = 0.
- Valid read: mem_rdata_i captured at the grant edge. Response has err_o = 0, rdata_o = captured word.
- No grant: mem_we_o = 0; mem_addr_o and mem_wdata_o = 0.
- Lock FSM:
  - UNLOCKED -> LOCKED when dbg_lock_i is sampled high and lock_timeout_o = 0. Counter cleared on entry.
  - LOCKED -> UNLOCKED when dbg_lock_i is sampled low.
  - LOCKED -> UNLOCKED with lock_timeout_o set when the counter reaches LockTimeout-1.
  - lock_timeout_o clears only when dbg_lock_i is sampled low. While it is set, the FSM stays UNLOCKED.
  - lock_active_o = (state == LOCKED).

## Timing
- Reset values: gnt_o = 0, rvalid_o = 0, rdata_o = 0, err_o = 0, mem_we_o = 0, lock_active_o = 0, lock_timeout_o = 0, state UNLOCKED, rr = 1, counter 0.
- While rst_i is high, gnt_o and mem_we_o are forced to 0.
- Grant latency is 0 cycles (combinational from req_i and state). Response latency is exactly 1 cycle after grant. Throughput is one access per cycle.
- Back-to-back write then read of the same word: the read in cycle N+1 returns the data written in cycle N.
- Reset asserted while a response is pending: the response is dropped and rvalid_o = 0 in the cycle after reset.
- dbg_lock_i rising in the same cycle as a port 1/2 request: that request can still be granted in this cycle. Exclusion starts the next cycle.
- Lock release cycle: ports 1 and 2 become eligible in the first UNLOCKED cycle.

## Test plan
- Reset, then port 1 read of addr 0x8 with mem word 2 = 0xDEADBEEF -> gnt_o = 010 same cycle; next cycle rvalid_o = 010, rdata_o = 0xDEADBEEF, err_o = 0.
- Ports 1 and 2 request continuously for 4 cycles -> grants 010, 100, 010, 100. Adding port 0 in cycle 3 -> grant 001 in cycle 3, then port 1 resumes alternation.
- Port 2 write to 0x10 with WriteProtect = 1 -> err_o = 1, mem_we_o = 0. Port 0 write 0x12345678 to 0x10, then port 2 read of 0x10 -> returns 0x12345678.
- Misaligned 0x6, and address NumWords*4 -> each granted, err_o = 1, rdata_o = 0, no ROM write.
- dbg_lock_i high with port 1 requesting -> port 1 gets no grant while lock_active_o = 1. Drop dbg_lock_i -> port 1 is granted the cycle after lock_active_o falls.
- LockTimeout = 8, dbg_lock_i held high -> lock_active_o high 8 cycles, then low with lock_timeout_o = 1 and port 1 served. Drop dbg_lock_i -> lock_timeout_o = 0.
